// File: rtl/mem_pkg.sv
// Shared definitions for the memory burst responder and its clients:
// FSM state encoding and the default line geometry / timing.
package mem_pkg;

    // Responder FSM states (encoding is visible on the debug port)
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RWAIT  = 2'd1,
        ST_RBURST = 2'd2,
        ST_WWAIT  = 2'd3
    } state_t;

    // Defaults shared with the cache so the line size always agrees
    localparam int unsigned DEF_DATA_W  = 32;
    localparam int unsigned DEF_DEPTH   = 1024;
    localparam int unsigned DEF_LATENCY = 20;
    localparam int unsigned DEF_BURST   = 4;

endpackage

// File: rtl/lat_counter.sv
// Loadable saturating down-counter used to time the first-word latency
// of both read and write requests.
module lat_counter #(
    parameter int unsigned WIDTH = 5
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic [WIDTH-1:0] value_i,
    output logic             zero_o
);

    logic [WIDTH-1:0] cnt_q;

    // Load on request acceptance, otherwise count down and hold at zero
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= value_i;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - WIDTH'(1);
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/mem_burst_responder.sv
// Main-memory model for the cache refill interface. Accepts one request at
// a time; reads return a whole line critical-word-first as a burst, writes
// are single-word write-through with a one-cycle acknowledge.
//
// Handshake: a request transfers on a rising edge where req_valid && req_ready.
// req_ready is high only in IDLE. The initiator holds req_valid and its payload
// stable until the transfer. Response beats carry no backpressure: resp_valid
// is asserted for exactly one cycle per beat and the initiator must take it.
module mem_burst_responder
    import mem_pkg::*;
#(
    parameter int unsigned DATA_W  = DEF_DATA_W,
    parameter int unsigned DEPTH   = DEF_DEPTH,
    parameter int unsigned LATENCY = DEF_LATENCY,
    parameter int unsigned BURST   = DEF_BURST
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic                       req_we,
    input  logic [31:0]                req_addr,
    input  logic [DATA_W-1:0]          req_wdata,
    output logic                       resp_valid,
    output logic [DATA_W-1:0]          resp_data,
    output logic [$clog2(BURST)-1:0]   resp_idx,
    output logic                       resp_last,
    output logic                       wr_done,
    output state_t                     dbg_state_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned BW = $clog2(BURST);
    localparam int unsigned CW = $clog2(LATENCY + 1);
    localparam logic [BW-1:0] LAST_BEAT = BW'(BURST - 1);
    localparam logic [CW-1:0] LAT_LOAD  = CW'(LATENCY - 1);

    state_t              state_q;
    logic [AW-1:0]       word_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [BW-1:0]       beat_q;
    logic                resp_valid_q;
    logic                resp_last_q;
    logic [DATA_W-1:0]   resp_data_q;
    logic [BW-1:0]       resp_idx_q;
    logic                wr_done_q;
    logic [DATA_W-1:0]   mem_q [DEPTH];

    logic                accept_d;
    logic                lat_zero;
    logic [AW-1:0]       word_d;
    logic [BW-1:0]       beat_idx_d;
    logic [AW-1:0]       beat_addr_d;
    logic                unused_addr_bits;

    assign req_ready = (state_q == ST_IDLE);
    assign accept_d  = req_valid && req_ready;

    // Word address; upper bits alias modulo DEPTH, byte offset is ignored
    assign word_d           = req_addr[AW+1:2];
    assign unused_addr_bits = ^{req_addr[31:AW+2], req_addr[1:0]};

    // Critical word first: the beat offset wraps inside the line
    assign beat_idx_d  = word_q[BW-1:0] + beat_q;
    assign beat_addr_d = {word_q[AW-1:BW], beat_idx_d};

    lat_counter #(
        .WIDTH (CW)
    ) u_lat (
        .clk_i   (clk),
        .rst_ni  (reset),
        .load_i  (accept_d),
        .value_i (LAT_LOAD),
        .zero_o  (lat_zero)
    );

    // Request payload capture at acceptance
    always_ff @(posedge clk) begin
        if (accept_d) begin
            word_q  <= word_d;
            wdata_q <= req_wdata;
        end
    end

    // Array write commits only at the latency expiry; reset drops a pending write
    always_ff @(posedge clk) begin
        if (reset && (state_q == ST_WWAIT) && lat_zero) begin
            mem_q[word_q] <= wdata_q;
        end
    end

    // Request FSM with registered response outputs
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            beat_q       <= '0;
            resp_valid_q <= 1'b0;
            resp_last_q  <= 1'b0;
            resp_data_q  <= '0;
            resp_idx_q   <= '0;
            wr_done_q    <= 1'b0;
        end else begin
            resp_valid_q <= 1'b0;
            resp_last_q  <= 1'b0;
            resp_data_q  <= '0;
            resp_idx_q   <= '0;
            wr_done_q    <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (accept_d) begin
                        beat_q  <= '0;
                        state_q <= req_we ? ST_WWAIT : ST_RWAIT;
                    end
                end
                ST_RWAIT: begin
                    if (lat_zero) begin
                        state_q      <= ST_RBURST;
                        resp_valid_q <= 1'b1;
                        resp_idx_q   <= beat_idx_d;
                        resp_data_q  <= mem_q[beat_addr_d];
                        resp_last_q  <= (beat_q == LAST_BEAT);
                        beat_q       <= beat_q + BW'(1);
                    end
                end
                ST_RBURST: begin
                    // The last beat was issued on the previous edge: line done
                    if (resp_last_q) begin
                        state_q <= ST_IDLE;
                        beat_q  <= '0;
                    end else begin
                        resp_valid_q <= 1'b1;
                        resp_idx_q   <= beat_idx_d;
                        resp_data_q  <= mem_q[beat_addr_d];
                        resp_last_q  <= (beat_q == LAST_BEAT);
                        beat_q       <= beat_q + BW'(1);
                    end
                end
                ST_WWAIT: begin
                    if (lat_zero) begin
                        state_q   <= ST_IDLE;
                        wr_done_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign resp_valid  = resp_valid_q;
    assign resp_last   = resp_last_q;
    assign resp_data   = resp_data_q;
    assign resp_idx    = resp_idx_q;
    assign wr_done     = wr_done_q;
    assign dbg_state_o = state_q;

endmodule

// File: doc/mem_burst_responder.md
Name: mem_burst_responder

Overview:
- Memory-side responder for the pipeline's cache/fetch refill interface. The pipeline or cache acts as initiator; this block accepts one request at a time.
- Reads return a full line as a burst of BURST words, delivered critical-word-first, after a fixed first-word latency.
- Writes are single-word write-through writes, acknowledged after the same latency.
- Serves as the main-memory model for the pipelined datapath and its caches.

Parameters:
- DATA_W, 32, data word width in bits.
- DEPTH, 1024, number of words in the array (power of 2).
- LATENCY, 20, cycles from request acceptance to the first read beat or to the write commit (>=1).
- BURST, 4, words per line (power of 2, >=2).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low reset (0 = reset, sampled on clk rising edge).
- req_valid  in  1  request present.
- req_ready  out  1  responder idle and able to accept.
- req_we  in  1  1 = write, 0 = line read.
- req_addr  in  32  byte address; bits [1:0] ignored.
- req_wdata  in  DATA_W  write data.
- resp_valid  out  1  read beat valid this cycle.
- resp_data  out  DATA_W  read beat data.
- resp_idx  out  log2(BURST)  word offset within the line of this beat.
- resp_last  out  1  final beat of the burst.
- wr_done  out  1  one-cycle write acknowledge.

Behaviour:
- States: IDLE, RWAIT, RBURST, WWAIT.
- req_ready = (state == IDLE), combinational from state.
- Handshake:
  - A request is accepted on a rising edge E0 where req_valid && req_ready.
  - req_we, req_addr and req_wdata are captured at E0.
  - The initiator holds req_valid until accepted.
  - No response backpressure: the initiator always sinks beats.
- Address mapping:
  - word = req_addr[log2(DEPTH)+1:2]; upper bits are ignored, so addresses alias modulo DEPTH words.
  - line base = word with its low log2(BURST) bits cleared.
  - start = word[log2(BURST)-1:0].
- Latency counter:
  - Loaded with LATENCY-1 at E0 and decremented each cycle.
  - The expiry edge is E_L, the LATENCY-th edge after E0.
- Read:
  - IDLE -> RWAIT at E0; RWAIT -> RBURST at E_L.
  - In the cycle after edge E_{L+k}, for k = 0..BURST-1:
    - resp_valid = 1
    - resp_idx = (start + k) mod BURST, wrapping within the line
    - resp_data = mem[base | resp_idx]
    - resp_last = (k == BURST-1)
  - RBURST -> IDLE at E_{L+BURST}.
  - Total occupancy is LATENCY + BURST cycles; the next request can be accepted at E_{L+BURST+1}.
- Write:
  - IDLE -> WWAIT at E0.
  - At E_L: mem[word] <= captured wdata, state -> IDLE.
  - wr_done = 1 for exactly the one cycle following E_L; req_ready is also 1 in that cycle.
- Read-after-write: requests are serialized, so a read accepted after wr_done observes the new data.
- Reset (reset == 0 at an edge):
  - state -> IDLE, counter -> 0, beat counter -> 0.
  - resp_valid, resp_last, wr_done, resp_data and resp_idx all -> 0.
  - A write that has not reached its commit edge is discarded. A burst in progress aborts with no further beats.
  - Array contents are not reset.
- LATENCY = 1: first beat or wr_done appears in the cycle immediately after E1.
- Outputs are registered. resp_* and wr_done are 0 whenever not explicitly asserted.

Decomposition:
- Shared package mem_pkg:
  - state encoding constants (IDLE=0, RWAIT=1, RBURST=2, WWAIT=3)
  - default LATENCY and BURST values, shared with the cache so line size matches.
- Natural sub-module lat_counter:
  - loadable down-counter, width $clog2(LATENCY+1)
  - inputs load/value; output zero flag
  - reused by both read and write paths.
- Array storage and the FSM stay in the top module.

Test Plan:
- Bench parameters: LATENCY=4, BURST=4, DEPTH=256.
- Reset check: hold reset=0 for 2 cycles, release -> req_ready=1, resp_valid=0, wr_done=0, resp_last=0.
- Write timing: write 0xDEADBEEF to addr 0x40, accepted at E0 -> req_ready=0 for cycles after E0..E3; wr_done=1 only in the cycle after E4; a read of 0x40 then returns 0xDEADBEEF on beat idx 0.
- Critical-word-first read:
  - preload words 4..7 with 0xA0, 0xA1, 0xA2, 0xA3 via writes.
  - read addr 0x18 -> 4 consecutive beats 0xA2/idx2, 0xA3/idx3, 0xA0/idx0, 0xA1/idx1.
  - first beat in the cycle after E4; resp_last only on the 4th beat; req_ready returns after E8.
- Busy hold: hold req_valid=1 with a second read during a burst -> not accepted until req_ready=1. Second-burst first beat appears exactly LATENCY edges after its acceptance; no beat overlap.
- Reset mid-operation: write 0x12345678 to 0x80, drive reset=0 at E2 -> wr_done never asserts, mem[0x80] unchanged. Same with reset during beat 2 of a read -> beats stop immediately, req_ready=1 after release.
- Address aliasing: write 0x55 to addr 0x400 (word 256, DEPTH=256) -> a read of addr 0x000 returns 0x55 on idx 0.
